// File: rtl/fadd_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe_if
// Brief    : Input/output handshake bundle of the pipelined FP adder.
//            Carries unf only when FADD_PIPE_UNF_EN is defined.
// Revision : 1.0
// ============================================================================
interface fadd_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int c_w = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [c_w-1:0]   x1;
    logic [c_w-1:0]   x2;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [c_w-1:0]   y;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;
`ifdef FADD_PIPE_UNF_EN
    logic             unf;
`endif

    modport slave (
        input  in_valid, x1, x2, sub, in_tag, out_ready,
        output in_ready, out_valid, y, ovf, out_tag
`ifdef FADD_PIPE_UNF_EN
        , unf
`endif
    );

    modport master (
        output in_valid, x1, x2, sub, in_tag, out_ready,
        input  in_ready, out_valid, y, ovf, out_tag
`ifdef FADD_PIPE_UNF_EN
        , unf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe
// Brief    : 3-stage FP add/sub (align, add, normalise/round), FTZ, RNE.
//            Optional underflow flag built when FADD_PIPE_UNF_EN is defined.
// Revision : 1.0
// ============================================================================
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rstn,
    fadd_pipe_if.slave  bus
);
    localparam int c_w     = 1 + EXP_W + MAN_W;
    localparam int c_aw    = MAN_W + 4;
    localparam int c_sw    = MAN_W + 5;
    localparam int c_lzw   = $clog2(c_sw + 1);
    localparam int c_shmax = MAN_W + 3;
    localparam int c_shw   = $clog2(c_shmax + 1);
    localparam int c_xw    = ((EXP_W > c_lzw) ? EXP_W : c_lzw) + 2;
    localparam logic signed [c_xw-1:0] c_emax = c_xw'((1 << EXP_W) - 1);

    logic w_en;
    assign w_en         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // ---------------- stage 1: unpack, specials, swap, align ----------------
    logic               w_s1, w_s2, w_z1, w_z2, w_nan1, w_nan2, w_inf1, w_inf2;
    logic [EXP_W-1:0]   w_e1, w_e2, w_eb, w_es, w_d;
    logic [MAN_W-1:0]   w_m1, w_m2, w_f1, w_f2;
    logic [MAN_W:0]     w_mb, w_ms;
    logic               w_swap, w_sb, w_lost, w_spec;
    logic [c_shw-1:0]   w_dsh;
    logic [c_aw-1:0]    w_ms_ext, w_ms_al;
    logic [c_w-1:0]     w_spec_y;

    assign w_s1   = bus.x1[c_w-1];
    assign w_e1   = bus.x1[c_w-2:MAN_W];
    assign w_m1   = bus.x1[MAN_W-1:0];
    assign w_s2   = bus.x2[c_w-1] ^ bus.sub;
    assign w_e2   = bus.x2[c_w-2:MAN_W];
    assign w_m2   = bus.x2[MAN_W-1:0];
    assign w_z1   = (w_e1 == '0);
    assign w_z2   = (w_e2 == '0);
    assign w_nan1 = (&w_e1) && (|w_m1);
    assign w_nan2 = (&w_e2) && (|w_m2);
    assign w_inf1 = (&w_e1) && !(|w_m1);
    assign w_inf2 = (&w_e2) && !(|w_m2);
    assign w_f1   = w_z1 ? '0 : w_m1;
    assign w_f2   = w_z2 ? '0 : w_m2;

    assign w_swap = {w_e2, w_f2} > {w_e1, w_f1};
    assign w_sb   = w_swap ? w_s2 : w_s1;
    assign w_eb   = w_swap ? w_e2 : w_e1;
    assign w_es   = w_swap ? w_e1 : w_e2;
    assign w_mb   = w_swap ? {!w_z2, w_f2} : {!w_z1, w_f1};
    assign w_ms   = w_swap ? {!w_z1, w_f1} : {!w_z2, w_f2};
    assign w_d    = w_eb - w_es;
    assign w_dsh  = (32'(w_d) > 32'(c_shmax)) ? c_shw'(c_shmax) : c_shw'(w_d);

    // Shifted-out bits collapse into the sticky position (bit 0)
    assign w_ms_ext = {w_ms, 3'b000};
    assign w_lost   = |(w_ms_ext & ~({c_aw{1'b1}} << w_dsh));
    assign w_ms_al  = (w_ms_ext >> w_dsh) | c_aw'(w_lost);

    always_comb begin
        w_spec   = 1'b1;
        w_spec_y = '0;
        if (w_nan2)
            w_spec_y = {w_s2, w_e2, 1'b1, w_m2[MAN_W-2:0]};
        else if (w_nan1)
            w_spec_y = {w_s1, w_e1, 1'b1, w_m1[MAN_W-2:0]};
        else if (w_inf1 && w_inf2 && (w_s1 != w_s2))
            w_spec_y = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (w_inf1)
            w_spec_y = {w_s1, bus.x1[c_w-2:0]};
        else if (w_inf2)
            w_spec_y = {w_s2, bus.x2[c_w-2:0]};
        else
            w_spec = 1'b0;
    end

    logic               r1_valid, r1_spec, r1_sign, r1_zsign, r1_op;
    logic [TAG_W-1:0]   r1_tag;
    logic [c_w-1:0]     r1_spec_y;
    logic [EXP_W-1:0]   r1_exp;
    logic [c_aw-1:0]    r1_mb, r1_ms;

    // ---------------- stage 2: add/sub, leading-one count -------------------
    logic [c_sw-1:0]    w_sum;
    logic [c_lzw-1:0]   w_lz;

    assign w_sum = r1_op ? ({1'b0, r1_mb} - {1'b0, r1_ms})
                         : ({1'b0, r1_mb} + {1'b0, r1_ms});

    always_comb begin
        w_lz = c_lzw'(c_sw);
        for (int i = 0; i < c_sw; i++)
            if (w_sum[i]) w_lz = c_lzw'(c_sw - 1 - i);
    end

    logic               r2_valid, r2_spec, r2_sign, r2_zsign;
    logic [TAG_W-1:0]   r2_tag;
    logic [c_w-1:0]     r2_spec_y;
    logic [EXP_W-1:0]   r2_exp;
    logic [c_sw-1:0]    r2_sum;
    logic [c_lzw-1:0]   r2_lz;

    // ---------------- stage 3: normalise, round, pack -----------------------
    logic [c_sw-1:0]        w_norm;
    logic                   w_rup, w_uflow, w_oflow, w_ovf3;
    logic [MAN_W+1:0]       w_mr;
    logic signed [c_xw-1:0] w_exp;
    logic [c_w-1:0]         w_y3;

    assign w_norm  = r2_sum << r2_lz;
    assign w_rup   = w_norm[3] & ((|w_norm[2:0]) | w_norm[4]);
    assign w_mr    = {1'b0, w_norm[c_sw-1:4]} + (MAN_W+2)'(w_rup);
    assign w_exp   = c_xw'(r2_exp) + c_xw'(1) - c_xw'(r2_lz) + c_xw'(w_mr[MAN_W+1]);
    assign w_uflow = w_exp[c_xw-1] || (w_exp == '0);
    assign w_oflow = !w_uflow && (w_exp >= c_emax);

`ifdef FADD_PIPE_UNF_EN
    logic w_unf3;
    logic r3_unf;
`endif

    always_comb begin
        w_y3   = {r2_sign, w_exp[EXP_W-1:0], w_mr[MAN_W-1:0]};
        w_ovf3 = 1'b0;
`ifdef FADD_PIPE_UNF_EN
        w_unf3 = 1'b0;
`endif
        if (r2_spec) begin
            w_y3 = r2_spec_y;
        end else if (r2_sum == '0) begin
            w_y3 = {r2_zsign, {(c_w-1){1'b0}}};
        end else if (w_uflow) begin
            w_y3 = {r2_sign, {(c_w-1){1'b0}}};
`ifdef FADD_PIPE_UNF_EN
            w_unf3 = 1'b1;
`endif
        end else if (w_oflow) begin
            w_y3   = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf3 = 1'b1;
        end
    end

    logic               r3_valid, r3_ovf;
    logic [TAG_W-1:0]   r3_tag;
    logic [c_w-1:0]     r3_y;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_valid <= 1'b0; r1_spec <= 1'b0; r1_sign <= 1'b0; r1_zsign <= 1'b0;
            r1_op <= 1'b0; r1_tag <= '0; r1_spec_y <= '0; r1_exp <= '0;
            r1_mb <= '0; r1_ms <= '0;
            r2_valid <= 1'b0; r2_spec <= 1'b0; r2_sign <= 1'b0; r2_zsign <= 1'b0;
            r2_tag <= '0; r2_spec_y <= '0; r2_exp <= '0; r2_sum <= '0; r2_lz <= '0;
            r3_valid <= 1'b0; r3_ovf <= 1'b0; r3_tag <= '0; r3_y <= '0;
`ifdef FADD_PIPE_UNF_EN
            r3_unf <= 1'b0;
`endif
        end else if (w_en) begin
            r1_valid  <= bus.in_valid;
            r1_spec   <= w_spec;
            r1_spec_y <= w_spec_y;
            r1_sign   <= w_sb;
            r1_zsign  <= w_s1 & w_s2;
            r1_op     <= w_s1 ^ w_s2;
            r1_tag    <= bus.in_tag;
            r1_exp    <= w_eb;
            r1_mb     <= {w_mb, 3'b000};
            r1_ms     <= w_ms_al;

            r2_valid  <= r1_valid;
            r2_spec   <= r1_spec;
            r2_spec_y <= r1_spec_y;
            r2_sign   <= r1_sign;
            r2_zsign  <= r1_zsign;
            r2_tag    <= r1_tag;
            r2_exp    <= r1_exp;
            r2_sum    <= w_sum;
            r2_lz     <= w_lz;

            r3_valid  <= r2_valid;
            r3_y      <= w_y3;
            r3_ovf    <= w_ovf3;
            r3_tag    <= r2_tag;
`ifdef FADD_PIPE_UNF_EN
            r3_unf    <= w_unf3;
`endif
        end
    end

    assign bus.out_valid = r3_valid;
    assign bus.y         = r3_y;
    assign bus.ovf       = r3_ovf;
    assign bus.out_tag   = r3_tag;
`ifdef FADD_PIPE_UNF_EN
    assign bus.unf       = r3_unf;
`endif

endmodule
`default_nettype wire

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Pipelined, parametrised floating-point adder/subtractor; successor to the team's single-cycle combinational FP32 adder.
- Three register stages: align, add, normalise/round.
- valid/ready handshake on input and output; carries a user tag alongside each operation.
- Sits between the FPU issue logic and the writeback arbiter; one operation accepted per cycle when not stalled.

Parameters:
EXP_W, 8, exponent width in bits
MAN_W, 23, stored mantissa width in bits (hidden bit excluded); word width W = 1+EXP_W+MAN_W
TAG_W, 4, width of the opaque tag passed through with each operation

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operands/op/tag valid this cycle
in_ready  out  1  block can accept an operation this cycle
x1  in  W  operand 1
x2  in  W  operand 2
sub  in  1  1: compute x1-x2; 0: compute x1+x2
in_tag  in  TAG_W  tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result this cycle
y  out  W  result
ovf  out  1  finite operands produced ±infinity
out_tag  out  TAG_W  tag of the operation in y

Behaviour:
- Reset (rstn low, asynchronous): all stage valid bits cleared.
  - Outputs during reset: out_valid=0, y=0, ovf=0, out_tag=0.
  - in_ready=1 from the first cycle after rstn rises.
  - Operations in flight when reset asserts are discarded; none is later emitted.
- Handshake and pipeline control:
  - Transfer in: in_valid&&in_ready. Transfer out: out_valid&&out_ready.
  - Advance enable en = !out_valid || out_ready. All three stages shift together when en=1 and hold when en=0.
  - in_ready = en. Combinational path exists from out_ready to in_ready; this is intentional.
  - Bubbles propagate as invalid stages. Latency is exactly 3 cycles from accept to out_valid when never stalled.
  - Throughput is 1 op/cycle. Results are returned strictly in order.
  - y, ovf and out_tag are held stable while out_valid && !out_ready.
- Arithmetic:
  - sub=1 inverts the sign of x2 before any other processing, NaN handling included.
  - Flush-to-zero on input: an operand with exponent 0 is treated as signed zero whatever its mantissa.
  - Alignment: the smaller-magnitude operand is shifted right, saturating at MAN_W+3 positions. Guard, round and sticky bits are kept.
  - Rounding: round-to-nearest, ties-to-even.
  - Flush-to-zero on output: a result whose rounded exponent is ≤0 becomes signed zero; its sign is the sign of the larger-magnitude operand.
  - Exact zero from cancellation returns +0, except (-0)+(-0), which returns -0.
  - Overflow: a rounded exponent ≥ all-ones returns ±inf with ovf=1.
  - ovf=0 whenever either operand is inf or NaN.
- Specials (evaluated in stage 1, carried down the pipe):
  - x2 NaN: return x2 with the mantissa MSB forced to 1.
  - Otherwise x1 NaN: return x1 with the mantissa MSB forced to 1.
  - inf + (-inf): default NaN = sign 1, exponent all ones, mantissa 100…0.
  - inf + finite, or inf + inf of the same sign: that inf.
- Stage content:
  - S1: unpack, specials, exponent difference, swap, align.
  - S2: add/sub and leading-one count.
  - S3: normalise, round, post-round carry, pack, ovf.

Optional Feature:
- Macro FADD_PIPE_UNF_EN.
- Defined:
  - Adds output port unf (1 bit), registered with y and held under stall; resets to 0.
  - unf=1 when a nonzero finite result was flushed to zero by output FTZ.
  - unf=0 for exact zero results and for specials.
- Undefined: port unf does not exist and no flag logic is built. y is identical either way.

Test Plan:
- FP32 default params, out_ready=1: x1=0x3F800000, x2=0x3F800000, sub=0, tag=5 -> exactly 3 cycles later y=0x40000000, ovf=0, out_tag=5.
- RNE ties:
  - 0x3F800000+0x33800000 -> 0x3F800000 (tie to even).
  - 0x3F800001+0x33800000 -> 0x3F800002.
  - 0x3F800000 sub 0x3F800000 -> 0x00000000.
  - 0x80000000+0x80000000 -> 0x80000000.
- Edge operands:
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, ovf=1.
  - 0x7F800000+0xFF800000 -> 0xFFC00000, ovf=0.
  - 0x7F800001+0x3F800000 -> 0x7FC00001.
  - 0x00000001+0x3F800000 -> 0x3F800000 (input FTZ).
- Back-to-back stream of 8 ops, tags 0..7, with out_ready low for cycles 4-9:
  - in_ready tracks out_ready (low whenever out_valid&&!out_ready).
  - y held stable while stalled; all 8 results emerge in tag order; none lost or duplicated.
- Reset asserted with 3 ops in flight: out_valid drops immediately (asynchronously). After release, a new op emerges after 3 cycles with no stale result before it.
- With FADD_PIPE_UNF_EN defined: 0x00800001 sub 0x00800000 -> y=0x00000000, unf=1. Then 0x3F800000 sub 0x3F800000 -> unf=0.
